// File: rtl/channel_pkg.sv
// Shared constants and helpers for the channel FIFO slice.
package channel_pkg;

   localparam int DEFAULT_DEPTH = 4;

   // Pointer width for a given depth, never narrower than one bit.
   function automatic int ptr_width(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/channel_if.sv
// Channel: valid/data-acknowledge link between producer and consumer.
interface Channel #(
   parameter int N = 1
);
   // A transfer happens on a rising clk edge when v and a are both 1; the
   // source holds d and v stable until that edge, the sink may raise a freely.
   logic [N-1:0] d;
   logic         v;
   logic         a;

   modport sink   (input d, input v, output a);
   modport source (output d, output v, input a);
endinterface

// File: rtl/channel_fifo_mem.sv
// Register-array storage: synchronous write, asynchronous read.
module channel_fifo_mem
   import channel_pkg::*;
#(
   parameter int N     = 1,
   parameter int Depth = DEFAULT_DEPTH
) (
   input  logic                          clk,
   input  logic                          we,
   input  logic [ptr_width(Depth)-1:0]   waddr,
   input  logic [N-1:0]                  wdata,
   input  logic [ptr_width(Depth)-1:0]   raddr,
   output logic [N-1:0]                  rdata
);

   logic [N-1:0] mem [Depth];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/channel_fifo.sv
// Elastic FIFO stage between two Channels with registered occupancy flags.
// Define CHANNEL_FIFO_HWM_EN to add the high_water / hwm_clear ports.
module channel_fifo
   import channel_pkg::*;
#(
   parameter int N               = -1,
   parameter int Depth           = DEFAULT_DEPTH,
   parameter int AlmostFullLevel = Depth - 1
) (
   input  logic                       clk,
   input  logic                       reset,
   Channel.sink                       in,
   Channel.source                     out,
   output logic [$clog2(Depth+1)-1:0] count,
   output logic                       almost_full
`ifdef CHANNEL_FIFO_HWM_EN
   ,
   input  logic                       hwm_clear,
   output logic [$clog2(Depth+1)-1:0] high_water
`endif
);

   localparam int CW = $clog2(Depth + 1);
   localparam int PW = ptr_width(Depth);

   if (N < 1 || Depth < 2 || AlmostFullLevel < 1 || AlmostFullLevel > Depth) begin : g_param_check
      $error("channel_fifo: illegal parameters N=%0d Depth=%0d AlmostFullLevel=%0d",
             N, Depth, AlmostFullLevel);
   end

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count_next;
   logic [N-1:0]  rdata;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   // Handshake flags come from registered count only, so out.a never reaches in.a.
   assign full  = (count == CW'(Depth));
   assign empty = (count == '0);
   assign in.a  = ~full;
   assign out.v = ~empty;
   assign push  = in.v & ~full;
   assign pop   = out.a & ~empty;
   assign out.d = empty ? 'x : rdata;

   channel_fifo_mem #(
      .N     (N),
      .Depth (Depth)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (in.d),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   always_comb begin
      count_next = count;
      if (push && !pop)      count_next = count + 1'b1;
      else if (pop && !push) count_next = count - 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         almost_full <= 1'b0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == PW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
         count       <= count_next;
         almost_full <= (count_next >= CW'(AlmostFullLevel));
      end
   end

`ifdef CHANNEL_FIFO_HWM_EN
   // Tracks the registered count, so a new peak shows up one edge later.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                  high_water <= '0;
      else if (hwm_clear)          high_water <= count;
      else if (count > high_water) high_water <= count;
   end
`endif

endmodule

// File: tb/tb_channel_fifo.sv
// Scoreboard bench for channel_fifo: Depth=4 and Depth=3 instances, N=8.
module tb_channel_fifo;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  Channel #(.N(8)) c4_in ();
  Channel #(.N(8)) c4_out ();
  Channel #(.N(8)) c3_in ();
  Channel #(.N(8)) c3_out ();

  logic [2:0] count4;
  logic       af4;
  logic [1:0] count3;
  logic       af3;
`ifdef CHANNEL_FIFO_HWM_EN
  logic       hwm_clear4;
  logic       hwm_clear3;
  logic [2:0] hw4;
  logic [1:0] hw3;
`endif

  channel_fifo #(.N(8), .Depth(4)) dut4 (
    .clk         (clk),
    .reset       (reset),
    .in          (c4_in),
    .out         (c4_out),
    .count       (count4),
    .almost_full (af4)
`ifdef CHANNEL_FIFO_HWM_EN
    ,
    .hwm_clear   (hwm_clear4),
    .high_water  (hw4)
`endif
  );

  channel_fifo #(.N(8), .Depth(3)) dut3 (
    .clk         (clk),
    .reset       (reset),
    .in          (c3_in),
    .out         (c3_out),
    .count       (count3),
    .almost_full (af3)
`ifdef CHANNEL_FIFO_HWM_EN
    ,
    .hwm_clear   (hwm_clear3),
    .high_water  (hw3)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp4_q[$];
  logic [7:0] exp3_q[$];
  int         pops4 = 0;
  int         pops3 = 0;
  logic [7:0] exp_w4;
  logic [7:0] exp_w3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after posedge, so at negedge v&a predicts the next edge's transfer.
  always @(negedge clk) begin
    if (!reset) begin
      exp4_q.delete();
      exp3_q.delete();
    end else begin
      if (c4_out.v && c4_out.a) begin
        checks++;
        if (exp4_q.size() == 0) begin
          failures++;
          $display("FAIL sb4_unexpected actual=%0h expected=none time=%0t", c4_out.d, $time);
        end else begin
          exp_w4 = exp4_q.pop_front();
          if (c4_out.d !== exp_w4) begin
            failures++;
            $display("FAIL sb4_data actual=%0h expected=%0h time=%0t", c4_out.d, exp_w4, $time);
          end
        end
        pops4++;
      end
      if (c4_in.v && c4_in.a) exp4_q.push_back(c4_in.d);
      checks++;
      if (count4 > 3'd4) begin
        failures++;
        $display("FAIL count4_bound actual=%0d expected<=4 time=%0t", count4, $time);
      end

      if (c3_out.v && c3_out.a) begin
        checks++;
        if (exp3_q.size() == 0) begin
          failures++;
          $display("FAIL sb3_unexpected actual=%0h expected=none time=%0t", c3_out.d, $time);
        end else begin
          exp_w3 = exp3_q.pop_front();
          if (c3_out.d !== exp_w3) begin
            failures++;
            $display("FAIL sb3_data actual=%0h expected=%0h time=%0t", c3_out.d, exp_w3, $time);
          end
        end
        pops3++;
      end
      if (c3_in.v && c3_in.a) exp3_q.push_back(c3_in.d);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int   base;
    int   guard;
    bit   acc;
    c4_in.v = 1'b0;  c4_in.d = '0;  c4_out.a = 1'b0;
    c3_in.v = 1'b0;  c3_in.d = '0;  c3_out.a = 1'b0;
`ifdef CHANNEL_FIFO_HWM_EN
    hwm_clear4 = 1'b0;
    hwm_clear3 = 1'b0;
`endif

    // reset and idle
    #1;
    check("rst_in_a", c4_in.a, 1);
    check("rst_out_v", c4_out.v, 0);
    repeat (3) step();
    reset = 1'b1;
    step();
    check("idle_count", count4, 0);
    check("idle_af", af4, 0);
    check("idle_out_v", c4_out.v, 0);
    check("idle_in_a", c4_in.a, 1);
`ifdef CHANNEL_FIFO_HWM_EN
    check("idle_hw", hw4, 0);
`endif

    // fill to full with out.a low
    c4_in.v = 1'b1;
    c4_in.d = 8'h11; step(); check("fill1_count", count4, 1); check("fill1_af", af4, 0);
    c4_in.d = 8'h22; step(); check("fill2_count", count4, 2); check("fill2_af", af4, 0);
    c4_in.d = 8'h33; step(); check("fill3_count", count4, 3); check("fill3_af", af4, 1);
    c4_in.d = 8'h44; step(); check("fill4_count", count4, 4); check("fill4_in_a", c4_in.a, 0);
    check("fill4_af", af4, 1);
    c4_in.d = 8'h55; step(); step();
    check("held_count", count4, 4);
    check("held_in_a", c4_in.a, 0);
    check("held_head", c4_out.d, 8'h11);

    // drain from full while 0x55 is offered
    c4_out.a = 1'b1;
    step(); check("pop1_count", count4, 3); check("pop1_in_a", c4_in.a, 1);
    step(); check("pop2_count", count4, 3);
    c4_in.v = 1'b0;
    step(); check("pop3_count", count4, 2); check("pop3_af", af4, 0);
    step(); check("pop4_count", count4, 1);
    c4_out.a = 1'b0;
    check("pop4_out_v", c4_out.v, 1);
    check("pop4_head", c4_out.d, 8'h55);
    c4_out.a = 1'b1;
    step();
    c4_out.a = 1'b0;
    check("drain_count", count4, 0);
    check("drain_out_v", c4_out.v, 0);
    check("dir_pops", pops4, 5);

    // streaming through Depth=3
    c3_out.a = 1'b1;
    c3_in.v  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      c3_in.d = 8'(i);
      step();
      check("stream_count", count3, 1);
    end
    c3_in.v = 1'b0;
    step();
    c3_out.a = 1'b0;
    check("stream_end_count", count3, 0);
    check("stream_pops", pops3, 20);
    check("stream_drained", exp3_q.size(), 0);

    // random source / sink on Depth=4
    base = pops4;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          c4_in.v = 1'b0;
          repeat ($urandom_range(0, 5)) step();
          c4_in.v = 1'b1;
          c4_in.d = 8'($urandom_range(0, 255));
          guard = 0;
          do begin
            @(negedge clk);
            acc = c4_in.a;
            @(posedge clk);
            #1;
            guard++;
          end while (!acc && guard < 100);
          if (!acc) begin
            checks++;
            failures++;
            $display("FAIL src_accept actual=stalled expected=accepted word=%0d", i);
            break;
          end
        end
        c4_in.v = 1'b0;
      end
      begin
        int sguard;
        sguard = 0;
        while ((pops4 - base) < 1000 && sguard < 30000) begin
          c4_out.a = 1'b0;
          repeat ($urandom_range(0, 5)) begin
            step();
            sguard++;
          end
          c4_out.a = 1'b1;
          step();
          sguard++;
        end
        c4_out.a = 1'b0;
      end
    join
    check("rand_pop_count", pops4 - base, 1000);
    check("rand_drained", exp4_q.size(), 0);
    check("rand_end_count", count4, 0);

    // asynchronous reset with two words buffered
    c4_in.v = 1'b1;
    c4_in.d = 8'hA1; step();
    c4_in.d = 8'hA2; step();
    c4_in.v = 1'b0;
    check("prerst_count", count4, 2);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midrst_out_v", c4_out.v, 0);
    check("midrst_in_a", c4_in.a, 1);
    check("midrst_count", count4, 0);
    check("midrst_af", af4, 0);
`ifdef CHANNEL_FIFO_HWM_EN
    check("midrst_hw", hw4, 0);
`endif
    step();
    reset = 1'b1;
    step();

    // refill to 2 after reset; old words must not reappear
    c4_in.v = 1'b1;
    c4_in.d = 8'hB1; step();
    c4_in.d = 8'hB2; step();
    c4_in.v = 1'b0;
    check("refill_count", count4, 2);
    check("refill_head", c4_out.d, 8'hB1);
    step();
`ifdef CHANNEL_FIFO_HWM_EN
    check("refill_hw", hw4, 2);
`endif
    c4_out.a = 1'b1;
    step(); step();
    c4_out.a = 1'b0;
    check("final_count", count4, 0);
`ifdef CHANNEL_FIFO_HWM_EN
    check("hw_hold", hw4, 2);
    hwm_clear4 = 1'b1;
    step();
    hwm_clear4 = 1'b0;
    check("hw_clear", hw4, 0);
`endif
    step();
    check("final_drained4", exp4_q.size(), 0);
    check("final_drained3", exp3_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
